// File: rtl/xmtr_pkg.sv
// Shared link definitions for the serial transmitter: header value, packet
// length, FSM state encodings and the packet assembly helper.
package xmtr_pkg;

  localparam logic [7:0]  LINK_HEAD = 8'hA5;
  localparam int unsigned PKT_LEN   = 16;
  localparam logic [2:0]  BIT_LAST  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } xmtr_state_e;

  function automatic logic [PKT_LEN-1:0] build_packet(input logic [7:0] head,
                                                      input logic [7:0] body);
    return {head, body};
  endfunction

endpackage

// File: rtl/xmtr_fifo.sv
// Synchronous FIFO feeding the transmitter when XMTR_FIFO_EN is defined.
// DEPTH must be a power of two; simultaneous push and pop is allowed when full.
module xmtr_fifo
  import xmtr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned    AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign pop_ok_s  = pop & ~empty;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rptr_r];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/xmtr.sv
// Serial packet transmitter: each buffered byte goes out MSB first as {HEAD, byte}.
// Define XMTR_FIFO_EN to replace the single holding register with xmtr_fifo.
module xmtr
  import xmtr_pkg::*;
#(
  parameter logic [7:0] HEAD = LINK_HEAD
`ifdef XMTR_FIFO_EN
  , parameter int unsigned FIFO_DEPTH = 4
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       writing,
  output logic       data_out,
  output logic       full,
  output logic       busy,
  output logic       overrun
);

  xmtr_state_e        state_r;
  xmtr_state_e        state_nxt_s;
  logic [2:0]         cnt_r;
  logic [2:0]         cnt_nxt_s;
  logic [PKT_LEN-1:0] shift_r;
  logic [PKT_LEN-1:0] shift_nxt_s;
  logic               data_out_r;
  logic               busy_r;
  logic               overrun_r;
  logic               pop_s;
  logic               push_s;
  logic               full_s;
  logic               buf_valid_s;
  logic [7:0]         buf_data_s;

  // A write while full still lands if the buffer is emptied on the same edge.
  assign push_s = writing & (~full_s | pop_s);

`ifdef XMTR_FIFO_EN
  logic fifo_full_s;
  logic fifo_empty_s;

  xmtr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (data_in),
    .dout  (buf_data_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign buf_valid_s = ~fifo_empty_s;
  assign full_s      = fifo_full_s;
`else
  logic       hold_valid_r;
  logic [7:0] hold_data_r;

  // Single-entry holding register between host and shifter.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'h00;
    end else if (push_s) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= data_in;
    end else if (pop_s) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  assign buf_valid_s = hold_valid_r;
  assign buf_data_s  = hold_data_r;
  assign full_s      = hold_valid_r;
`endif

  assign full     = full_s;
  assign data_out = data_out_r;
  assign busy     = busy_r;
  assign overrun  = overrun_r;

  // Next-state, counter and shifter update; pop_s marks the buffer-to-shifter move.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shift_nxt_s = shift_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (buf_valid_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_HEAD;
          cnt_nxt_s   = BIT_LAST;
          shift_nxt_s = build_packet(HEAD, buf_data_s);
        end else begin
          shift_nxt_s = {PKT_LEN{1'b0}};
        end
      end
      ST_HEAD: begin
        shift_nxt_s = {shift_r[PKT_LEN-2:0], 1'b0};
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_BODY;
          cnt_nxt_s   = BIT_LAST;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      ST_BODY: begin
        if (cnt_r != 3'd0) begin
          shift_nxt_s = {shift_r[PKT_LEN-2:0], 1'b0};
          cnt_nxt_s   = cnt_r - 3'd1;
        end else if (buf_valid_s) begin
          // Chain the next packet straight onto the last body bit.
          pop_s       = 1'b1;
          state_nxt_s = ST_HEAD;
          cnt_nxt_s   = BIT_LAST;
          shift_nxt_s = build_packet(HEAD, buf_data_s);
        end else begin
          state_nxt_s = ST_IDLE;
          shift_nxt_s = {PKT_LEN{1'b0}};
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 3'd0;
        shift_nxt_s = {PKT_LEN{1'b0}};
      end
    endcase
  end

  // State, shifter and registered line/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      shift_r    <= {PKT_LEN{1'b0}};
      data_out_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      data_out_r <= (state_nxt_s != ST_IDLE) & shift_nxt_s[PKT_LEN-1];
      busy_r     <= (state_nxt_s != ST_IDLE);
      overrun_r  <= writing & full_s & ~pop_s;
    end
  end

endmodule
